n_bit_adder: RTL and testbench
==============================

Name: n_bit_adder

Overview:
Parameterised N-bit two's-complement / unsigned adder, built as a ripple-carry chain of full-adder cells.
Used as the accumulate stage of the shift-and-add multipliers in the FFT datapath (instantiated with N=17), where the sum is consumed in the same clock cycle.
It provides a zero-latency combinational sum plus carry/overflow flags.
It also provides a one-cycle registered copy of sum and flags for pipelined users.

Parameters:
N, 17, operand/result width in bits (legal range N >= 2)

Ports:
clk  input  1  rising-edge clock; used only by the registered outputs
rst  input  1  synchronous, active-high reset; used only by the registered outputs
input1  input  N  operand A (unsigned or two's complement)
input2  input  N  operand B (unsigned or two's complement)
answer  output  N  combinational sum, (input1 + input2) mod 2^N
carry_out  output  1  combinational unsigned carry out of bit N-1
overflow  output  1  combinational signed overflow flag
answer_q  output  N  registered answer
carry_q  output  1  registered carry_out
overflow_q  output  1  registered overflow

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Structure: N full-adder cells in a ripple chain, generated from N. Carry into bit 0 is constant 0.
  - Cell i: s_i = a_i ^ b_i ^ c_i; c_(i+1) = a_i&b_i | a_i&c_i | b_i&c_i.
- answer = s[N-1:0]. Wraps modulo 2^N; the result is never saturated.
- carry_out = c_N.
- overflow = c_N ^ c_(N-1). Equivalently, the operand sign bits are equal and differ from answer[N-1].
- Combinational path timing:
  - Purely combinational, with zero cycles of latency.
  - Independent of clk and rst: answer, carry_out and overflow stay valid while rst is high.
  - Outputs settle within one ripple delay of any input change.
  - No latches.
- Registered path, on each rising edge of clk:
  - If rst = 1: answer_q <= 0, carry_q <= 0, overflow_q <= 0.
  - Else: answer_q <= answer, carry_q <= carry_out, overflow_q <= overflow.
  - Latency is exactly 1 cycle. Registers update every cycle; there is no enable.
- Power-up values: registered outputs are undefined until the first clock edge with rst high. Combinational outputs are defined as soon as inputs are.
- Reset mid-operation: the edge with rst high clears the registered outputs. Registered outputs resume tracking on the first edge with rst low, showing the sum of the inputs present at that edge.
- Unused outputs: any output may be left unconnected, e.g. the multiplier uses only input1, input2 and answer.
- Signedness: the sum bits are identical for unsigned and signed interpretation. Only the carry_out vs overflow meaning differs.
- No X-propagation beyond the standard operators: an X on any input bit may only corrupt that bit and higher sum bits.

Test Plan:
- Basic add (N=17): input1=0x00005, input2=0x00003 -> answer=0x00008, carry_out=0, overflow=0; answer_q=0x00008 one edge later.
- Unsigned wrap: 0x1FFFF + 0x00001 -> answer=0x00000, carry_out=1, overflow=0 (signed -1+1=0).
- Signed positive overflow: 0x0FFFF + 0x00001 -> answer=0x10000, carry_out=0, overflow=1.
- Signed negative overflow and carry: 0x10000 + 0x10000 -> answer=0x00000, carry_out=1, overflow=1.
- Multiplier accumulate pattern: 0x1FFFD (-3) + 0x00005 -> answer=0x00002, carry_out=1, overflow=0.
  - Then feed answer back as input1 with input2=0x00005 -> answer=0x00007.
- Reset and latency:
  - Hold rst=1 for 2 edges with inputs 0x00005 + 0x00003 -> answer_q=0, carry_q=0, overflow_q=0, while answer=0x00008 throughout.
  - Drop rst -> answer_q=0x00008 after the next edge.
  - Change inputs every cycle -> answer_q equals the previous cycle's answer.

Source files
------------

// File: rtl/n_bit_adder.sv
// N-bit ripple-carry adder with unsigned carry and signed overflow flags.
// Zero-latency combinational sum plus a one-cycle registered copy.
module n_bit_adder #(
    parameter int N = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] input1,
    input  logic [N-1:0] input2,
    output logic [N-1:0] answer,
    output logic         carry_out,
    output logic         overflow,
    output logic [N-1:0] answer_q,
    output logic         carry_q,
    output logic         overflow_q
);

    logic [N-1:0] sum_d;
    logic [N:0]   c_d;

    // Ripple chain of full-adder cells; carry into bit 0 is tied low.
    always_comb begin
        sum_d = '0;
        c_d   = '0;
        c_d[0] = 1'b0;
        for (int k = 0; k < N; k++) begin
            sum_d[k]  = input1[k] ^ input2[k] ^ c_d[k];
            c_d[k+1]  = (input1[k] & input2[k])
                      | (input1[k] & c_d[k])
                      | (input2[k] & c_d[k]);
        end
    end

    assign answer    = sum_d;
    assign carry_out = c_d[N];
    // Signed overflow: carry into the sign bit differs from carry out.
    assign overflow  = c_d[N] ^ c_d[N-1];

    // Registered copy of sum and flags, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            answer_q   <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            answer_q   <= answer;
            carry_q    <= carry_out;
            overflow_q <= overflow;
        end
    end

endmodule

// File: tb/tb_n_bit_adder.sv
// Scoreboard bench for n_bit_adder: random and directed operands
// checked against an integer-arithmetic reference model.
module tb_n_bit_adder;

    localparam int N = 17;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] input1;
    logic [N-1:0] input2;
    logic [N-1:0] answer;
    logic         carry_out;
    logic         overflow;
    logic [N-1:0] answer_q;
    logic         carry_q;
    logic         overflow_q;

    int total = 0;
    int bad   = 0;
    int pushed = 0;
    int popped = 0;

    logic [N+1:0] sb_q[$];

    n_bit_adder #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .input1    (input1),
        .input2    (input2),
        .answer    (answer),
        .carry_out (carry_out),
        .overflow  (overflow),
        .answer_q  (answer_q),
        .carry_q   (carry_q),
        .overflow_q(overflow_q)
    );

    always #5 clk = ~clk;

    // Reference: {overflow, carry, sum} from plain integer arithmetic.
    function automatic logic [N+1:0] model(input logic [N-1:0] a,
                                           input logic [N-1:0] b);
        longint ua, ub, us, sa, sb, ss, lim;
        logic   ov;
        logic [N-1:0] s;
        logic   co;
        lim = longint'(1) << (N - 1);
        ua = longint'(a);
        ub = longint'(b);
        us = ua + ub;
        sa = (ua >= lim) ? ua - 2 * lim : ua;
        sb = (ub >= lim) ? ub - 2 * lim : ub;
        ss = sa + sb;
        ov = (ss > lim - 1) || (ss < -lim);
        s  = N'(us % (2 * lim));
        co = (us >= 2 * lim);
        return {ov, co, s};
    endfunction

    task automatic step(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic r);
        logic [N+1:0] e;
        input1 = a;
        input2 = b;
        rst    = r;
        #1;
        e = model(a, b);
        total++;
        if ({overflow, carry_out, answer} !== e) begin
            bad++;
            $display("FAIL comb a=%h b=%h rst=%b got ov=%b c=%b s=%h exp ov=%b c=%b s=%h",
                     a, b, r, overflow, carry_out, answer,
                     e[N+1], e[N], e[N-1:0]);
        end
        sb_q.push_back(r ? '0 : e);
        pushed++;
        @(posedge clk);
        #2;
    endtask

    // Monitor: registered outputs are compared just after every edge.
    initial begin
        logic [N+1:0] exp_v;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                exp_v = sb_q.pop_front();
                popped++;
                total++;
                if ({overflow_q, carry_q, answer_q} !== exp_v) begin
                    bad++;
                    $display("FAIL reg got ov=%b c=%b s=%h exp ov=%b c=%b s=%h",
                             overflow_q, carry_q, answer_q,
                             exp_v[N+1], exp_v[N], exp_v[N-1:0]);
                end
            end
        end
    end

    initial begin
        logic [N-1:0] a, b;
        logic         r;
        step(17'h00005, 17'h00003, 1'b1);
        step(17'h00005, 17'h00003, 1'b1);
        step(17'h00005, 17'h00003, 1'b0);
        step(17'h1FFFF, 17'h00001, 1'b0);
        step(17'h0FFFF, 17'h00001, 1'b0);
        step(17'h10000, 17'h10000, 1'b0);
        step(17'h1FFFD, 17'h00005, 1'b0);
        step(17'h00002, 17'h00005, 1'b0);
        step(17'h1FFFF, 17'h1FFFF, 1'b0);
        step(17'h0FFFF, 17'h0FFFF, 1'b0);
        step(17'h00000, 17'h00000, 1'b0);
        step(17'h1FFFF, 17'h00001, 1'b1);
        step(17'h0FFFF, 17'h00001, 1'b0);
        for (int i = 0; i < 300; i++) begin
            a = N'($urandom);
            b = N'($urandom);
            r = ($urandom_range(0, 15) == 0);
            step(a, b, r);
        end
        repeat (2) @(posedge clk);
        #3;
        total++;
        if (sb_q.size() != 0 || popped != pushed) begin
            bad++;
            $display("FAIL drain left=%0d popped=%0d pushed=%0d",
                     sb_q.size(), popped, pushed);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
